// File: rtl/systolic_wb_if.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_wb_if
//  Description : Result stream (valid/ready) and B-region BRAM port bundle
//                for the systolic write-back controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface systolic_wb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    // Result stream from the array drain
    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic              res_ready;

    // B-region BRAM read/write port
    logic [ADDR_W-1:0] addr_rd;
    logic [DATA_W-1:0] bram_rdata;
    logic [ADDR_W-1:0] addr_wr;
    logic [DATA_W-1:0] wdata;
    logic              wen;

    // Controller side
    modport master (
        input  res_valid, res_data, bram_rdata,
        output res_ready, addr_rd, addr_wr, wdata, wen
    );

    // Environment side (array drain + BRAM)
    modport slave (
        output res_valid, res_data, bram_rdata,
        input  res_ready, addr_rd, addr_wr, wdata, wen
    );
endinterface
`default_nettype wire

// File: rtl/systolic_wb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_wb_ctrl
//  Description : Write-back end of the systolic datapath. Buffers result
//                words in a small FIFO, optionally accumulates them lane-wise
//                onto the existing B word, and writes them row-major into the
//                B region of BRAM through a two-stage read/write pipeline.
//  Options     : WB_QMASK_EN - adds q_bits_i; every written lane is masked
//                to its low q_bits bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module systolic_wb_ctrl #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 64,
    parameter int LANE_W        = 16,
    parameter int WORDS_PER_ROW = 2,
    parameter int ROW_STRIDE    = 128,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_b_i,
    input  logic [10:0]       matrix_size_i,
    input  logic              add_en_i,
`ifdef WB_QMASK_EN
    input  logic [4:0]        q_bits_i,
`endif
    systolic_wb_if.master     bus,
    output logic              busy_o,
    output logic              done_o,
    output logic [1:0]        current_state_o
);

    localparam int LANES = DATA_W / LANE_W;
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              done_q, done_d;

    // Configuration latched on start
    logic [ADDR_W-1:0] base_q;
    logic [31:0]       n_words_q;
    logic              add_en_q;
`ifdef WB_QMASK_EN
    logic [4:0]        q_bits_q;
`endif

    // Progress counters
    logic [31:0]       accepted_q;
    logic [31:0]       popped_q;
    logic [31:0]       row_q;
    logic [31:0]       col_q;

    // Input FIFO; pointers carry one extra bit to tell full from empty
    logic [DATA_W-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr_q;
    logic [PTR_W:0]    rd_ptr_q;

    // Stage-2 (write) registers
    logic              wen_q;
    logic [ADDR_W-1:0] addr_wr_q;
    logic [DATA_W-1:0] res_q;

    logic [PTR_W:0]    w_count;
    logic              w_full;
    logic              w_empty;
    logic              w_ready;
    logic              w_push;
    logic              w_pop;
    logic              w_last_pop;
    logic              w_start;
    logic [31:0]       w_start_nwords;
    logic [ADDR_W-1:0] w_addr_rd;
    logic [DATA_W-1:0] w_wdata;

    assign w_count        = wr_ptr_q - rd_ptr_q;
    assign w_full         = (w_count == (PTR_W+1)'(FIFO_DEPTH));
    assign w_empty        = (w_count == '0);
    assign w_start        = (state_q == S_IDLE) && start_i;
    assign w_start_nwords = 32'(matrix_size_i) * 32'(WORDS_PER_ROW);

    // Never accept beyond the word count of this matrix, so an overrunning
    // producer simply stalls until the next start.
    assign w_ready    = (state_q == S_RUN) && !w_full && (accepted_q < n_words_q);
    assign w_push     = bus.res_valid && w_ready && !rst;
    assign w_pop      = (state_q == S_RUN) && !w_empty;
    assign w_last_pop = w_pop && (popped_q == (n_words_q - 32'd1));

    assign w_addr_rd  = base_q + ADDR_W'(row_q * 32'(ROW_STRIDE)) + ADDR_W'(col_q * 32'd8);

    // Lane-wise add (or pass-through); each lane wraps on its own width
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [LANE_W-1:0] w_sum;
        assign w_sum = res_q[l*LANE_W +: LANE_W]
                     + (add_en_q ? bus.bram_rdata[l*LANE_W +: LANE_W] : '0);
`ifdef WB_QMASK_EN
        logic [LANE_W-1:0] w_mask;
        assign w_mask = LANE_W'((32'd1 << q_bits_q) - 32'd1);
        assign w_wdata[l*LANE_W +: LANE_W] = w_sum & w_mask;
`else
        assign w_wdata[l*LANE_W +: LANE_W] = w_sum;
`endif
    end

    // Reset gates the strobes combinationally so an abort takes effect in
    // the very cycle rst is high.
    assign bus.res_ready   = w_ready && !rst;
    assign bus.addr_rd     = w_addr_rd;
    assign bus.addr_wr     = addr_wr_q;
    assign bus.wen         = wen_q && !rst;
    assign bus.wdata       = (wen_q && !rst) ? w_wdata : '0;
    assign busy_o          = (state_q != S_IDLE) || done_q;
    assign done_o          = done_q;
    assign current_state_o = state_q;

    // FSM state and done pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    // FSM next-state: the last pop moves to FLUSH so done lands one cycle
    // after the final write strobe.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = (w_start_nwords == 32'd0) ? S_FLUSH : S_RUN;
                end
            end
            S_RUN: begin
                if (w_last_pop) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_mem_q[wr_ptr_q[PTR_W-1:0]] <= bus.res_data;
        end
    end

    // Config latch, counters, FIFO pointers and the stage-2 write registers
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q     <= '0;
            n_words_q  <= '0;
            add_en_q   <= 1'b0;
`ifdef WB_QMASK_EN
            q_bits_q   <= 5'd16;
`endif
            accepted_q <= '0;
            popped_q   <= '0;
            row_q      <= '0;
            col_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            wen_q      <= 1'b0;
            addr_wr_q  <= '0;
            res_q      <= '0;
        end else begin
            if (w_start) begin
                base_q     <= base_addr_b_i;
                n_words_q  <= w_start_nwords;
                add_en_q   <= add_en_i;
`ifdef WB_QMASK_EN
                q_bits_q   <= q_bits_i;
`endif
                accepted_q <= '0;
                popped_q   <= '0;
                row_q      <= '0;
                col_q      <= '0;
            end
            if (w_push) begin
                wr_ptr_q   <= wr_ptr_q + 1'b1;
                accepted_q <= accepted_q + 32'd1;
            end
            wen_q <= w_pop;
            if (w_pop) begin
                res_q     <= fifo_mem_q[rd_ptr_q[PTR_W-1:0]];
                rd_ptr_q  <= rd_ptr_q + 1'b1;
                popped_q  <= popped_q + 32'd1;
                addr_wr_q <= w_addr_rd;
                if (col_q == 32'(WORDS_PER_ROW - 1)) begin
                    col_q <= '0;
                    row_q <= row_q + 32'd1;
                end else begin
                    col_q <= col_q + 32'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_wb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_systolic_wb_ctrl
//  Description : Self-checking bench for systolic_wb_ctrl. A word-level model
//                predicts every write (address, data, cycle) from the words
//                handed over on the result stream; a monitor compares each
//                cycle, and directed tests pin literal values.
//  Options     : WB_QMASK_EN - also exercises the lane mask.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_systolic_wb_ctrl;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int WPR    = 2;
    localparam int STRIDE = 128;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base = '0;
    logic [10:0] msize = '0;
    logic        add_en = 1'b0;
`ifdef WB_QMASK_EN
    logic [4:0]  q_bits = 5'd16;
`endif
    logic        busy, done;
    logic [1:0]  cstate;

    systolic_wb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    systolic_wb_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LANE_W(16),
        .WORDS_PER_ROW(WPR), .ROW_STRIDE(STRIDE), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start),
        .base_addr_b_i(base), .matrix_size_i(msize), .add_en_i(add_en),
`ifdef WB_QMASK_EN
        .q_bits_i(q_bits),
`endif
        .bus(bus), .busy_o(busy), .done_o(done), .current_state_o(cstate)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- word-level model ----------------
    typedef struct {
        logic [31:0] addr;
        logic [63:0] data;
        int          cyc;
    } wr_t;

    logic [63:0] bmem [logic [31:0]];
    logic [63:0] src [$];
    wr_t         expq [$];
    wr_t         wlog [$];

    logic [31:0] m_base = '0;
    int          m_nwords = 0;
    logic        m_add = 1'b0;
    int          m_q = 16;
    int          m_k = 0;
    int          m_written = 0;
    int          m_last_exp = -100;
    int          m_start_cyc = -10;
    int          done_due = -1;
    bit          m_active = 1'b0;
    int          done_cnt = 0;
    int          last_done_cyc = -1;

    function automatic logic [63:0] bread(input logic [31:0] a);
        if (bmem.exists(a)) return bmem[a];
        return {a ^ 32'h5A5A_0F0F, ~a};
    endfunction

    function automatic logic [63:0] mdata(input logic [63:0] r, input logic [63:0] b,
                                          input logic a, input int q);
        logic [63:0] o;
        int unsigned s;
        o = '0;
        for (int l = 0; l < 4; l++) begin
            s = r[l*16 +: 16] + (a ? b[l*16 +: 16] : 16'd0);
            s = s % 65536;
`ifdef WB_QMASK_EN
            if (q < 16) s = s & ((32'd1 << q) - 1);
`endif
            o[l*16 +: 16] = s[15:0];
        end
        return o;
    endfunction

    // Producer: offers src words in order; on each transfer the model
    // predicts the resulting write.
    initial begin
        bit hs;
        wr_t e;
        int  k;
        bus.res_valid = 1'b0;
        bus.res_data  = '0;
        forever begin
            @(negedge clk);
            hs = bus.res_valid && bus.res_ready;
            if (hs) begin
                if (m_k >= m_nwords) begin
                    checks++;
                    errors++;
                    $display("FAIL overrun: word %0d accepted, limit %0d", m_k, m_nwords);
                end else begin
                    k      = m_k;
                    e.addr = m_base + 32'((k / WPR) * STRIDE) + 32'((k % WPR) * 8);
                    e.data = mdata(bus.res_data, bread(e.addr), m_add, m_q);
                    e.cyc  = (cyc + 2 > m_last_exp + 1) ? cyc + 2 : m_last_exp + 1;
                    m_last_exp = e.cyc;
                    expq.push_back(e);
                end
                m_k++;
            end
            @(posedge clk);
            #1;
            if (hs && src.size() > 0) void'(src.pop_front());
            bus.res_valid = (src.size() > 0);
            bus.res_data  = (src.size() > 0) ? src[0] : 64'd0;
        end
    end

    // BRAM model: data for addr_rd appears the following cycle
    initial begin
        logic [31:0] ra;
        bus.bram_rdata = '0;
        forever begin
            @(negedge clk);
            ra = bus.addr_rd;
            @(posedge clk);
            #1;
            bus.bram_rdata = bread(ra);
        end
    end

    // Compare process: writes, done and busy every cycle
    initial begin
        wr_t e, w;
        forever begin
            @(negedge clk);
            if (rst) begin
                expq.delete();
                m_active = 1'b0;
                done_due = -1;
            end else begin
                if (cyc == m_start_cyc + 1) m_active = 1'b1;
                if (bus.wen) begin
                    w.addr = bus.addr_wr;
                    w.data = bus.wdata;
                    w.cyc  = cyc;
                    wlog.push_back(w);
                    if (expq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL wen: unexpected write addr %h data %h", w.addr, w.data);
                    end else begin
                        e = expq.pop_front();
                        chk("wr_addr", w.addr, e.addr);
                        chk("wr_data", w.data, e.data);
                        chk("wr_cycle", w.cyc, e.cyc);
                        m_written++;
                        if (m_written == m_nwords) done_due = cyc + 1;
                    end
                end
                chk("done", done, (cyc == done_due));
                chk("busy", busy, m_active);
                if (done) begin
                    done_cnt++;
                    last_done_cyc = cyc;
                    m_active = 1'b0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] b, input int s, input logic a, input int q);
        m_base     = b;
        m_nwords   = s * WPR;
        m_add      = a;
        m_q        = q;
        m_k        = 0;
        m_written  = 0;
        m_last_exp = -100;
        m_start_cyc = cyc;
        done_due   = (s == 0) ? cyc + 2 : -1;
        start  = 1'b1;
        base   = b;
        msize  = 11'(s);
        add_en = a;
`ifdef WB_QMASK_EN
        q_bits = 5'(q);
`endif
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0, n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < budget) begin
            tick(1);
            n++;
        end
        chk("done_seen", done_cnt - d0, 1);
    endtask

    initial begin
        int n0, n;
        logic [31:0] exp_addr [4];
        exp_addr[0] = 32'h1000; exp_addr[1] = 32'h1008;
        exp_addr[2] = 32'h1080; exp_addr[3] = 32'h1088;

        // Reset state
        rst = 1'b1;
        tick(3);
        chk("rst_ready", bus.res_ready, 0);
        chk("rst_wen", bus.wen, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_addr_rd", bus.addr_rd, 0);
        chk("rst_addr_wr", bus.addr_wr, 0);
        chk("rst_wdata", bus.wdata, 0);
        chk("rst_state", cstate, 0);
        rst = 1'b0;
        tick(2);

        // Direct write, 2x2 words
        wlog.delete();
        do_start(32'h1000, 2, 1'b0, 16);
        chk("run_state", cstate, 1);
        src = '{64'h11, 64'h22, 64'h33, 64'h44};
        wait_done(50);
        chk("direct_count", wlog.size(), 4);
        for (int i = 0; i < 4 && i < wlog.size(); i++) begin
            chk("direct_addr", wlog[i].addr, exp_addr[i]);
            chk("direct_data", wlog[i].data, 64'h11 * (i + 1));
        end
        chk("direct_done_lat", last_done_cyc - wlog[wlog.size()-1].cyc, 1);
        chk("idle_state", cstate, 0);
        chk("idle_busy", busy, 0);
        tick(2);

        // Accumulate with per-lane wrap
        wlog.delete();
        bmem[32'h2000] = 64'hFFFF_0001_0002_0003;
        do_start(32'h2000, 1, 1'b1, 16);
        src = '{64'h0001_0001_0001_0001, 64'h0000_0000_0000_0005};
        wait_done(50);
        chk("acc_count", wlog.size(), 2);
        if (wlog.size() > 0) begin
            chk("acc_addr", wlog[0].addr, 32'h2000);
            chk("acc_data", wlog[0].data, 64'h0000_0002_0003_0004);
        end
        tick(2);

        // Back-to-back stream of 8 words with accumulate
        wlog.delete();
        do_start(32'h3000, 4, 1'b1, 16);
        for (int i = 0; i < 8; i++) src.push_back({$urandom, $urandom});
        wait_done(80);
        chk("stream_count", wlog.size(), 8);
        if (wlog.size() == 8) chk("stream_last_addr", wlog[7].addr, 32'h3188);
        tick(2);

        // Overrun: size 1 with 3 words offered
        wlog.delete();
        do_start(32'h5000, 1, 1'b0, 16);
        src = '{64'hA1, 64'hA2, 64'hA3};
        wait_done(50);
        chk("ovr_accepted", m_k, 2);
        chk("ovr_left", src.size(), 1);
        chk("ovr_ready", bus.res_ready, 0);
        tick(3);
        chk("ovr_ready_late", bus.res_ready, 0);
        chk("ovr_count", wlog.size(), 2);
        src.delete();
        tick(2);

        // Zero size
        wlog.delete();
        do_start(32'h6000, 0, 1'b0, 16);
        wait_done(10);
        chk("zero_done_lat", last_done_cyc - m_start_cyc, 2);
        chk("zero_wen", wlog.size(), 0);
        tick(2);

        // Reset after the first write
        wlog.delete();
        do_start(32'h7000, 2, 1'b0, 16);
        src = '{64'hB1, 64'hB2, 64'hB3, 64'hB4};
        n = 0;
        while (wlog.size() < 1 && n < 20) begin
            tick(1);
            n++;
        end
        chk("mid_first_write", wlog.size(), 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        src.delete();
        chk("mid_state", cstate, 0);
        chk("mid_ready", bus.res_ready, 0);
        chk("mid_busy", busy, 0);
        n0 = wlog.size();
        tick(5);
        chk("mid_no_wen", wlog.size(), n0);
        do_start(32'h7100, 1, 1'b0, 16);
        src = '{64'hC1, 64'hC2};
        wait_done(50);
        chk("mid_restart_count", wlog.size(), n0 + 2);
        if (wlog.size() == n0 + 2) chk("mid_restart_addr", wlog[n0+1].addr, 32'h7108);
        tick(2);

`ifdef WB_QMASK_EN
        // Lane mask with q_bits = 15
        wlog.delete();
        do_start(32'h8000, 1, 1'b0, 15);
        src = '{64'h0001_0002_7FFF_8000, 64'hFFFF_FFFF_FFFF_FFFF};
        wait_done(50);
        chk("qmask_count", wlog.size(), 2);
        if (wlog.size() > 0) chk("qmask_data", wlog[0].data, 64'h0001_0002_7FFF_0000);
        tick(2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
